// File: rtl/conv_line_buffer.sv
// Line buffer for the 3x3 convolution stage: turns a raster pixel stream into
// M_DEPTH-tall column vectors using cascaded line memories, with syncs delayed to match.
module conv_line_buffer #(
    parameter int COLORDEPTH  = 8,
    parameter int SCREENWIDTH = 1600,
    parameter int LINE_END    = 2048,
    parameter int M_DEPTH     = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [COLORDEPTH-1:0]                 pix_i,
    input  logic                                  dv_i,
    input  logic                                  hs_i,
    input  logic                                  vs_i,
    output logic [M_DEPTH-1:0][COLORDEPTH-1:0]    vect_o,
    output logic                                  dv_o,
    output logic                                  hs_o,
    output logic                                  vs_o,
    output logic                                  ovf_o
);

    localparam int AW   = $clog2(LINE_END);
    localparam int NMEM = M_DEPTH - 1;
    localparam int LCW  = (M_DEPTH > 2) ? $clog2(M_DEPTH) : 1;
    localparam logic [LCW-1:0] LC_MAX = LCW'(M_DEPTH - 1);

    if (SCREENWIDTH > LINE_END || (LINE_END & (LINE_END - 1)) != 0 || M_DEPTH < 2) begin : g_badParams
        $error("conv_line_buffer: LINE_END must be a power of two >= SCREENWIDTH and M_DEPTH >= 2");
    end

    logic [AW:0]            r_addr;
    logic [LCW-1:0]         r_lineCnt;
    logic                   r_ovf;
    logic                   r_dvQ;
    logic                   r_hsQ;
    logic                   r_vsQ;
    logic [COLORDEPTH-1:0]  r_pix;
    logic [NMEM-1:0]        r_mask;
    logic [AW-1:0]          r_wrAddr;
    logic                   r_casEn;
    logic [COLORDEPTH-1:0]  r_rd  [NMEM];
    logic [COLORDEPTH-1:0]  r_mem [NMEM][LINE_END];

    logic                   w_vsRise;
    logic                   w_dvFall;
    logic [AW:0]            w_addr;
    logic [AW-1:0]          w_addrIdx;
    logic                   w_inRange;
    logic                   w_wrEn;
    logic [LCW-1:0]         w_lineCnt;

    // A frame start forces column and line count to zero for the current pixel.
    assign w_vsRise  = vs_i & ~r_vsQ;
    assign w_dvFall  = ~dv_i & r_dvQ;
    assign w_addr    = w_vsRise ? '0 : r_addr;
    assign w_addrIdx = w_addr[AW-1:0];
    assign w_inRange = ~w_addr[AW];
    assign w_wrEn    = dv_i & w_inRange & ~rst;
    assign w_lineCnt = w_vsRise ? '0 : r_lineCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_lineCnt <= '0;
            r_ovf     <= 1'b0;
            r_dvQ     <= 1'b0;
            r_hsQ     <= 1'b0;
            r_vsQ     <= 1'b0;
            r_pix     <= '0;
            r_mask    <= '0;
            r_wrAddr  <= '0;
            r_casEn   <= 1'b0;
        end else begin
            r_dvQ    <= dv_i;
            r_hsQ    <= hs_i;
            r_vsQ    <= vs_i;
            r_casEn  <= w_wrEn;
            r_wrAddr <= w_addrIdx;

            if (!dv_i) begin
                r_addr <= '0;
            end else if (w_inRange) begin
                r_addr <= w_addr + 1'b1;
            end else begin
                r_addr <= w_addr;
            end

            if (w_vsRise) begin
                r_lineCnt <= '0;
            end else if (w_dvFall && r_lineCnt < LC_MAX) begin
                r_lineCnt <= r_lineCnt + 1'b1;
            end

            if (w_vsRise) begin
                r_ovf <= 1'b0;
            end else if (dv_i && !w_inRange) begin
                r_ovf <= 1'b1;
            end

            // Upper rows are masked until enough lines exist, and on overflowing pixels.
            if (dv_i) begin
                r_pix <= pix_i;
                for (int j = 1; j <= NMEM; j++) begin
                    r_mask[j-1] <= w_inRange && (w_lineCnt >= LCW'(j));
                end
            end
        end
    end

    // Synchronous read-before-write; the cascade into deeper memories lands one cycle
    // later at the same column, once the old contents have been read out.
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            for (int k = 0; k < NMEM; k++) begin
                r_rd[k] <= r_mem[k][w_addrIdx];
            end
            r_mem[0][w_addrIdx] <= pix_i;
        end
        if (r_casEn) begin
            for (int k = 1; k < NMEM; k++) begin
                r_mem[k][r_wrAddr] <= r_rd[k-1];
            end
        end
    end

    always_comb begin
        vect_o    = '0;
        vect_o[0] = r_pix;
        for (int j = 1; j < M_DEPTH; j++) begin
            vect_o[j] = r_mask[j-1] ? r_rd[j-1] : '0;
        end
    end

    assign dv_o  = r_dvQ;
    assign hs_o  = r_hsQ;
    assign vs_o  = r_vsQ;
    assign ovf_o = r_ovf;

endmodule

// File: tb/tb_conv_line_buffer.sv
// Scoreboard bench for conv_line_buffer: a per-column pixel history model predicts
// every output cycle; a monitor pops and compares one cycle after each input.
module tb_conv_line_buffer;

    localparam int COLORDEPTH  = 8;
    localparam int SCREENWIDTH = 1600;
    localparam int LINE_END    = 2048;
    localparam int M_DEPTH     = 3;

    typedef struct packed {
        logic                               dv;
        logic                               hs;
        logic                               vs;
        logic                               ovf;
        logic                               checkVect;
        logic [M_DEPTH-1:0]                 known;
        logic [M_DEPTH-1:0][COLORDEPTH-1:0] vect;
    } exp_t;

    logic                               clk = 1'b0;
    logic                               rst;
    logic [COLORDEPTH-1:0]              pix_i;
    logic                               dv_i;
    logic                               hs_i;
    logic                               vs_i;
    logic [M_DEPTH-1:0][COLORDEPTH-1:0] vect_o;
    logic                               dv_o;
    logic                               hs_o;
    logic                               vs_o;
    logic                               ovf_o;

    exp_t expQ [$];
    int   hist [LINE_END][$];
    int   mAddr;
    int   mLineCnt;
    bit   mPrevDv;
    bit   mPrevVs;
    bit   mOvf;
    int   compared   = 0;
    int   mismatched = 0;

    conv_line_buffer #(
        .COLORDEPTH (COLORDEPTH),
        .SCREENWIDTH(SCREENWIDTH),
        .LINE_END   (LINE_END),
        .M_DEPTH    (M_DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .pix_i (pix_i),
        .dv_i  (dv_i),
        .hs_i  (hs_i),
        .vs_i  (vs_i),
        .vect_o(vect_o),
        .dv_o  (dv_o),
        .hs_o  (hs_o),
        .vs_o  (vs_o),
        .ovf_o (ovf_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and predict what the outputs show one cycle later.
    // Row j of a column is the pixel written at that column j writes ago.
    task automatic applyStimulus(input bit r, input bit d, input bit h, input bit v,
                                 input logic [COLORDEPTH-1:0] p);
        exp_t e;
        bit   vsRise;
        bit   dvFall;
        int   a;
        int   lc;
        @(negedge clk);
        rst   = r;
        dv_i  = d;
        hs_i  = h;
        vs_i  = v;
        pix_i = p;
        e = '0;
        if (r) begin
            mAddr = 0; mLineCnt = 0; mOvf = 0; mPrevDv = 0; mPrevVs = 0;
            e.checkVect = 1'b1;
            e.known     = '1;
        end else begin
            vsRise = v && !mPrevVs;
            dvFall = !d && mPrevDv;
            a  = vsRise ? 0 : mAddr;
            lc = vsRise ? 0 : mLineCnt;
            if (vsRise) mOvf = 0;
            if (d) begin
                e.checkVect = 1'b1;
                e.known[0]  = 1'b1;
                e.vect[0]   = p;
                if (a < LINE_END) begin
                    for (int j = 1; j < M_DEPTH; j++) begin
                        if (lc < j) begin
                            e.known[j] = 1'b1;
                        end else if (hist[a].size() >= j) begin
                            e.known[j] = 1'b1;
                            e.vect[j]  = COLORDEPTH'(hist[a][j-1]);
                        end
                    end
                    hist[a].push_front(int'(p));
                    if (hist[a].size() > M_DEPTH - 1) void'(hist[a].pop_back());
                    mAddr = a + 1;
                end else begin
                    for (int j = 1; j < M_DEPTH; j++) e.known[j] = 1'b1;
                    mOvf  = 1;
                    mAddr = a;
                end
            end else begin
                mAddr = 0;
            end
            if (vsRise) mLineCnt = 0;
            else if (dvFall && mLineCnt < M_DEPTH - 1) mLineCnt = mLineCnt + 1;
            mPrevDv = d;
            mPrevVs = v;
            e.dv = d;
            e.hs = h;
            e.vs = v;
        end
        e.ovf = mOvf;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [M_DEPTH*COLORDEPTH-1:0] bitMask;
        compared++;
        if ({dv_o, hs_o, vs_o, ovf_o} !== {e.dv, e.hs, e.vs, e.ovf}) begin
            mismatched++;
            $display("[TB] FAIL ctrl dv/hs/vs/ovf: got %b%b%b%b want %b%b%b%b",
                     dv_o, hs_o, vs_o, ovf_o, e.dv, e.hs, e.vs, e.ovf);
        end
        if (e.checkVect) begin
            for (int j = 0; j < M_DEPTH; j++) begin
                bitMask[j*COLORDEPTH +: COLORDEPTH] = e.known[j] ? '1 : '0;
            end
            compared++;
            if ((vect_o & bitMask) !== (e.vect & bitMask)) begin
                mismatched++;
                $display("[TB] FAIL vect: got %h want %h (checked bits %h)",
                         vect_o, e.vect, bitMask);
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic vsPulse();
        repeat (2) applyStimulus(0, 0, 0, 1, '0);
        repeat (2) applyStimulus(0, 0, 0, 0, '0);
    endtask

    task automatic sendLine(input int width, input bit ramp, input int lineIdx, input int blank);
        for (int c = 0; c < width; c++) begin
            applyStimulus(0, 1, 0, 0, ramp ? COLORDEPTH'((lineIdx * 16 + c) % 256)
                                           : COLORDEPTH'($urandom));
        end
        applyStimulus(0, 0, 1, 0, '0);
        for (int b = 1; b < blank; b++) applyStimulus(0, 0, 0, 0, '0);
    endtask

    initial begin
        rst = 1'b1; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; pix_i = '0;
        mAddr = 0; mLineCnt = 0; mOvf = 0; mPrevDv = 0; mPrevVs = 0;
        repeat (3) applyStimulus(1, 0, 0, 0, '0);

        // Ramp frame: priming of rows 1 and 2 over the first three lines.
        vsPulse();
        for (int l = 0; l < 3; l++) sendLine(SCREENWIDTH, 1, l, 8);

        // Reset mid-line: following lines restart priming.
        vsPulse();
        sendLine(SCREENWIDTH, 0, 0, 6);
        for (int c = 0; c < 100; c++) applyStimulus(0, 1, 0, 0, COLORDEPTH'($urandom));
        repeat (3) applyStimulus(1, 1, 0, 0, COLORDEPTH'($urandom));
        repeat (4) applyStimulus(0, 0, 0, 0, '0);
        sendLine(SCREENWIDTH, 0, 0, 6);
        sendLine(SCREENWIDTH, 0, 0, 6);

        // Overflow line, then a normal line, then a frame start clearing the flag.
        vsPulse();
        sendLine(LINE_END + 2, 0, 0, 6);
        sendLine(SCREENWIDTH, 0, 0, 6);
        vsPulse();
        sendLine(100, 0, 0, 6);

        // Frame start coinciding with the end of a line.
        vsPulse();
        sendLine(SCREENWIDTH, 0, 0, 6);
        for (int c = 0; c < 500; c++) applyStimulus(0, 1, 0, 0, COLORDEPTH'($urandom));
        applyStimulus(0, 0, 0, 1, '0);
        applyStimulus(0, 0, 0, 0, '0);
        sendLine(SCREENWIDTH, 0, 0, 6);
        sendLine(200, 0, 0, 6);

        // Back-to-back lines of unequal width with single-cycle blanking.
        vsPulse();
        sendLine(1600, 0, 0, 1);
        sendLine(800, 0, 0, 1);
        sendLine(1600, 0, 0, 1);

        repeat (4) applyStimulus(0, 0, 0, 0, '0);
        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending entries want 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
